// File: rtl/red_pitaya_asg_seq_sched_pkg.sv
// red_pitaya_asg_seq_sched_pkg: FSM states, descriptor field widths and packed-bus helpers
// shared by the ASG segment scheduler and its descriptor FIFO.
package red_pitaya_asg_seq_sched_pkg;

   typedef enum logic [1:0] {S_IDLE, S_PRELOAD, S_RUN, S_STOP} state_t;

   localparam int AMP_W  = 14;
   localparam int NCYC_W = 16;

   // Packed descriptor: {amp, dc, start, end, step, ncyc, last}
   function automatic int desc_w(input int rsz);
      return 2 * AMP_W + 3 * (rsz + 16) + NCYC_W + 1;
   endfunction

   // Bit offset of slot k inside a packed set_*_all bus whose fields are w bits wide
   function automatic int slot_off(input logic [1:0] k, input int w);
      return int'(k) * w;
   endfunction

endpackage

// File: rtl/red_pitaya_asg_seq_sched_fifo.sv
// asg_desc_fifo: synchronous show-ahead descriptor FIFO with occupancy count.
// Ports: clk_i/rstn_i clock and async active-low reset; flush_i empties the FIFO;
// push_i/din_i write (ignored while ready_o is low); pop_i/dout_o read the head;
// cnt_o occupancy; ready_o registered not-full.
module asg_desc_fifo
   import red_pitaya_asg_seq_sched_pkg::*;
#(
   parameter int W     = 8,
   parameter int DEPTH = 8
) (
   input  logic                     clk_i,
   input  logic                     rstn_i,
   input  logic                     flush_i,
   input  logic                     push_i,
   input  logic [W-1:0]             din_i,
   input  logic                     pop_i,
   output logic [W-1:0]             dout_o,
   output logic [$clog2(DEPTH):0]   cnt_o,
   output logic                     ready_o
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [AW:0]   cnt_q, cnt_d;
   logic          ready_q, push_ok, pop_ok;

   always_comb begin
      push_ok = push_i && ready_q;
      pop_ok  = pop_i && cnt_q != '0;
      cnt_d   = flush_i ? '0 : cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         wr_q    <= '0;
         rd_q    <= '0;
         cnt_q   <= '0;
         ready_q <= 1'b1;
      end else begin
         cnt_q   <= cnt_d;
         ready_q <= cnt_d != (AW+1)'(DEPTH);
         wr_q    <= flush_i ? '0 : wr_q + AW'(push_ok);
         rd_q    <= flush_i ? '0 : rd_q + AW'(pop_ok);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_q] <= din_i;
   end

   assign dout_o  = mem_q[rd_q];
   assign cnt_o   = cnt_q;
   assign ready_o = ready_q;

endmodule

// File: rtl/red_pitaya_asg_seq_sched.sv
// red_pitaya_asg_seq_sched: segment scheduler feeding a ring of N_BUF parameter slots of
// one multi-buffer ASG channel from a descriptor FIFO, refilling each slot once retired.
// Ports: dac_clk_i/dac_rstn_i clock and async active-low reset; desc_* descriptor push;
// arm_i/abort_i software commands; buf_done_i channel slot-finished pulse;
// set_*_all_o packed slot parameters, set_rst_o/trig_sw_o channel control;
// busy_o/seq_done_o/underrun_o status; active_slot_o playing slot; fifo_cnt_o occupancy.
module red_pitaya_asg_seq_sched
   import red_pitaya_asg_seq_sched_pkg::*;
#(
   parameter int RSZ        = 14,
   parameter int N_BUF      = 4,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          dac_clk_i,
   input  logic                          dac_rstn_i,
   input  logic                          desc_valid_i,
   output logic                          desc_ready_o,
   input  logic [AMP_W-1:0]              desc_amp_i,
   input  logic [AMP_W-1:0]              desc_dc_i,
   input  logic [RSZ+15:0]               desc_start_i,
   input  logic [RSZ+15:0]               desc_end_i,
   input  logic [RSZ+15:0]               desc_step_i,
   input  logic [NCYC_W-1:0]             desc_ncyc_i,
   input  logic                          desc_last_i,
   input  logic                          arm_i,
   input  logic                          abort_i,
   input  logic                          buf_done_i,
   output logic [AMP_W*N_BUF-1:0]        set_amp_all_o,
   output logic [AMP_W*N_BUF-1:0]        set_dc_all_o,
   output logic [(RSZ+16)*N_BUF-1:0]     set_start_all_o,
   output logic [(RSZ+16)*N_BUF-1:0]     set_end_all_o,
   output logic [(RSZ+16)*N_BUF-1:0]     set_step_all_o,
   output logic [NCYC_W*N_BUF-1:0]       set_ncyc_all_o,
   output logic                          set_rst_o,
   output logic                          trig_sw_o,
   output logic                          busy_o,
   output logic                          seq_done_o,
   output logic                          underrun_o,
   output logic [1:0]                    active_slot_o,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);

   localparam int PW = RSZ + 16;
   localparam int DW = desc_w(RSZ);

   state_t                  state_q, state_d;
   logic [AMP_W*N_BUF-1:0]  amp_q, dc_q;
   logic [PW*N_BUF-1:0]     start_q, end_q, step_q;
   logic [NCYC_W*N_BUF-1:0] ncyc_q;
   logic [N_BUF-1:0]        valid_q, last_q;
   logic [1:0]              load_ptr_q, active_q, nxt_slot;
   logic                    last_loaded_q, set_rst_q, trig_q, busy_q, seq_done_q, underrun_q;
   logic                    empty, pop;
   logic [DW-1:0]           fifo_din, fifo_dout;
   logic [AMP_W-1:0]        f_amp, f_dc;
   logic [PW-1:0]           f_start, f_end, f_step;
   logic [NCYC_W-1:0]       f_ncyc;
   logic                    f_last;

   assign fifo_din = {desc_amp_i, desc_dc_i, desc_start_i, desc_end_i, desc_step_i, desc_ncyc_i, desc_last_i};
   assign {f_amp, f_dc, f_start, f_end, f_step, f_ncyc, f_last} = fifo_dout;

   asg_desc_fifo #(.W(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk_i   (dac_clk_i),
      .rstn_i  (dac_rstn_i),
      .flush_i (abort_i),
      .push_i  (desc_valid_i),
      .din_i   (fifo_din),
      .pop_i   (pop),
      .dout_o  (fifo_dout),
      .cnt_o   (fifo_cnt_o),
      .ready_o (desc_ready_o)
   );

   // While running, the playing slot and the one the channel switches to next are never
   // overwritten, so the channel always reads a stable slot right after buf_done.
   always_comb begin
      empty    = fifo_cnt_o == '0;
      nxt_slot = active_q + 2'd1;
      pop      = !abort_i && !empty && !last_loaded_q && !valid_q[load_ptr_q] &&
                 (state_q == S_PRELOAD ||
                  (state_q == S_RUN && load_ptr_q != active_q && load_ptr_q != nxt_slot));
      state_d  = abort_i ? S_IDLE :
                 state_q == S_IDLE    ? (arm_i ? S_PRELOAD : S_IDLE) :
                 state_q == S_PRELOAD ? ((valid_q[0] && (&valid_q || last_loaded_q || empty)) ? S_RUN : S_PRELOAD) :
                 state_q == S_RUN     ? ((buf_done_i && (last_q[active_q] || !valid_q[nxt_slot])) ? S_STOP : S_RUN) :
                 S_IDLE;
   end

   // set_rst_o is released on entry to RUN and held low through STOP, so a terminal
   // buf_done raises it two cycles later; abort raises it on the next cycle.
   always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
      if (!dac_rstn_i) begin
         state_q       <= S_IDLE;
         amp_q         <= '0;
         dc_q          <= '0;
         start_q       <= '0;
         end_q         <= '0;
         step_q        <= '0;
         ncyc_q        <= '0;
         valid_q       <= '0;
         last_q        <= '0;
         load_ptr_q    <= '0;
         active_q      <= '0;
         last_loaded_q <= 1'b0;
         set_rst_q     <= 1'b1;
         trig_q        <= 1'b0;
         busy_q        <= 1'b0;
         seq_done_q    <= 1'b0;
         underrun_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         busy_q    <= state_d != S_IDLE;
         set_rst_q <= abort_i || !(state_q == S_RUN || state_d == S_RUN);
         trig_q    <= state_q == S_PRELOAD && state_d == S_RUN;
         if (pop) begin
            amp_q[slot_off(load_ptr_q, AMP_W) +: AMP_W]    <= f_amp;
            dc_q[slot_off(load_ptr_q, AMP_W) +: AMP_W]     <= f_dc;
            start_q[slot_off(load_ptr_q, PW) +: PW]        <= f_start;
            end_q[slot_off(load_ptr_q, PW) +: PW]          <= f_end;
            step_q[slot_off(load_ptr_q, PW) +: PW]         <= f_step;
            ncyc_q[slot_off(load_ptr_q, NCYC_W) +: NCYC_W] <= f_ncyc;
            valid_q[load_ptr_q] <= 1'b1;
            last_q[load_ptr_q]  <= f_last;
            if (f_last) last_loaded_q <= 1'b1;
            load_ptr_q <= load_ptr_q + 2'd1;
         end
         if (state_q == S_RUN && buf_done_i && !abort_i) begin
            valid_q[active_q] <= 1'b0;
            active_q          <= nxt_slot;
            if (last_q[active_q]) seq_done_q <= 1'b1;
            else if (!valid_q[nxt_slot]) underrun_q <= 1'b1;
         end
         if (state_q == S_IDLE && arm_i && !abort_i) begin
            load_ptr_q    <= '0;
            active_q      <= '0;
            last_loaded_q <= 1'b0;
            seq_done_q    <= 1'b0;
            underrun_q    <= 1'b0;
         end
         if (abort_i || state_q == S_STOP) begin
            valid_q       <= '0;
            last_q        <= '0;
            last_loaded_q <= 1'b0;
         end
      end
   end

   assign set_amp_all_o   = amp_q;
   assign set_dc_all_o    = dc_q;
   assign set_start_all_o = start_q;
   assign set_end_all_o   = end_q;
   assign set_step_all_o  = step_q;
   assign set_ncyc_all_o  = ncyc_q;
   assign set_rst_o       = set_rst_q;
   assign trig_sw_o       = trig_q;
   assign busy_o          = busy_q;
   assign seq_done_o      = seq_done_q;
   assign underrun_o      = underrun_q;
   assign active_slot_o   = active_q;

endmodule

// File: tb/tb_red_pitaya_asg_seq_sched.sv
// tb_red_pitaya_asg_seq_sched: directed self-checking bench for the ASG segment scheduler.
module tb_red_pitaya_asg_seq_sched;

   logic         clk = 1'b0, rstn = 1'b0;
   logic         desc_valid = 1'b0, desc_ready, desc_last = 1'b0;
   logic [13:0]  desc_amp = '0, desc_dc = '0;
   logic [29:0]  desc_start = '0, desc_end = '0, desc_step = '0;
   logic [15:0]  desc_ncyc = '0;
   logic         arm = 1'b0, abort = 1'b0, buf_done = 1'b0;
   logic [55:0]  amp_all, dc_all;
   logic [119:0] start_all, end_all, step_all;
   logic [63:0]  ncyc_all;
   logic         set_rst, trig, busy, seq_done, underrun;
   logic [1:0]   active;
   logic [3:0]   fifo_cnt;

   int checks = 0, errors = 0, trig_cnt = 0;

   red_pitaya_asg_seq_sched #(.RSZ(14), .N_BUF(4), .FIFO_DEPTH(8)) dut (
      .dac_clk_i       (clk),
      .dac_rstn_i      (rstn),
      .desc_valid_i    (desc_valid),
      .desc_ready_o    (desc_ready),
      .desc_amp_i      (desc_amp),
      .desc_dc_i       (desc_dc),
      .desc_start_i    (desc_start),
      .desc_end_i      (desc_end),
      .desc_step_i     (desc_step),
      .desc_ncyc_i     (desc_ncyc),
      .desc_last_i     (desc_last),
      .arm_i           (arm),
      .abort_i         (abort),
      .buf_done_i      (buf_done),
      .set_amp_all_o   (amp_all),
      .set_dc_all_o    (dc_all),
      .set_start_all_o (start_all),
      .set_end_all_o   (end_all),
      .set_step_all_o  (step_all),
      .set_ncyc_all_o  (ncyc_all),
      .set_rst_o       (set_rst),
      .trig_sw_o       (trig),
      .busy_o          (busy),
      .seq_done_o      (seq_done),
      .underrun_o      (underrun),
      .active_slot_o   (active),
      .fifo_cnt_o      (fifo_cnt)
   );

   always #5 clk = ~clk;

   always @(negedge clk) if (trig) trig_cnt++;

   task automatic push(input int i, input logic last);
      desc_amp   = 14'(100 + i);
      desc_dc    = 14'(200 + i);
      desc_start = 30'(i * 1000);
      desc_end   = 30'(i * 1000 + 999);
      desc_step  = 30'(i + 1);
      desc_ncyc  = 16'(i);
      desc_last  = last;
      desc_valid = 1'b1;
      @(negedge clk);
      desc_valid = 1'b0;
   endtask

   task automatic arm_pulse();
      arm = 1'b1;
      @(negedge clk);
      arm = 1'b0;
   endtask

   task automatic bd();
      buf_done = 1'b1;
      @(negedge clk);
      buf_done = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic wait_trig(output int n);
      n = 0;
      while (trig !== 1'b1 && n < 30) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++; if (set_rst !== 1'b1) begin errors++; $display("FAIL reset_set_rst got %0b want 1", set_rst); end
      checks++; if (trig !== 1'b0) begin errors++; $display("FAIL reset_trig got %0b want 0", trig); end
      checks++; if (desc_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", desc_ready); end
      checks++; if ({busy, seq_done, underrun} !== 3'b000) begin errors++; $display("FAIL reset_status got %03b want 000", {busy, seq_done, underrun}); end
      checks++; if (fifo_cnt !== 4'd0) begin errors++; $display("FAIL reset_cnt got %0d want 0", fifo_cnt); end
      checks++; if (amp_all !== 56'd0 || start_all !== 120'd0) begin errors++; $display("FAIL reset_buses got %h/%h want 0", amp_all, start_all); end
      rstn = 1'b1;
      @(negedge clk);
      checks++; if (busy !== 1'b0 || set_rst !== 1'b1) begin errors++; $display("FAIL idle_after_reset got busy %0b rst %0b want 0/1", busy, set_rst); end
   endtask

   task automatic test_basic();
      int n, t0;
      push(1, 1'b0); push(2, 1'b0); push(3, 1'b1);
      checks++; if (fifo_cnt !== 4'd3) begin errors++; $display("FAIL basic_cnt got %0d want 3", fifo_cnt); end
      t0 = trig_cnt;
      arm_pulse();
      checks++; if (busy !== 1'b1 || set_rst !== 1'b1) begin errors++; $display("FAIL basic_preload got busy %0b rst %0b want 1/1", busy, set_rst); end
      wait_trig(n);
      checks++; if (n !== 4) begin errors++; $display("FAIL basic_trig_latency got %0d want 4", n); end
      checks++; if (set_rst !== 1'b0) begin errors++; $display("FAIL basic_run_rst got %0b want 0", set_rst); end
      checks++; if (amp_all[28 +: 14] !== 14'd103) begin errors++; $display("FAIL basic_slot2_amp got %0d want 103", amp_all[28 +: 14]); end
      checks++; if (step_all[30 +: 30] !== 30'd3 || ncyc_all[16 +: 16] !== 16'd2) begin errors++; $display("FAIL basic_slot1 got step %0d ncyc %0d want 3/2", step_all[30 +: 30], ncyc_all[16 +: 16]); end
      checks++; if (active !== 2'd0 || fifo_cnt !== 4'd0) begin errors++; $display("FAIL basic_start got act %0d cnt %0d want 0/0", active, fifo_cnt); end
      bd();
      checks++; if (active !== 2'd1 || set_rst !== 1'b0) begin errors++; $display("FAIL basic_bd1 got act %0d rst %0b want 1/0", active, set_rst); end
      bd();
      checks++; if (active !== 2'd2 || set_rst !== 1'b0) begin errors++; $display("FAIL basic_bd2 got act %0d rst %0b want 2/0", active, set_rst); end
      buf_done = 1'b1;
      @(negedge clk);
      buf_done = 1'b0;
      checks++; if ({set_rst, busy, seq_done} !== 3'b011) begin errors++; $display("FAIL basic_stop got rst/busy/done %03b want 011", {set_rst, busy, seq_done}); end
      @(negedge clk);
      checks++; if ({set_rst, busy, seq_done} !== 3'b101) begin errors++; $display("FAIL basic_idle got rst/busy/done %03b want 101", {set_rst, busy, seq_done}); end
      checks++; if (trig_cnt - t0 !== 1) begin errors++; $display("FAIL basic_trig_pulses got %0d want 1", trig_cnt - t0); end
   endtask

   task automatic test_refill();
      int n;
      for (int i = 1; i <= 6; i++) push(i, i == 6);
      arm_pulse();
      checks++; if (seq_done !== 1'b0) begin errors++; $display("FAIL refill_arm_clear got %0b want 0", seq_done); end
      wait_trig(n);
      checks++; if (n !== 5) begin errors++; $display("FAIL refill_trig_latency got %0d want 5", n); end
      checks++; if (fifo_cnt !== 4'd2 || amp_all[42 +: 14] !== 14'd104) begin errors++; $display("FAIL refill_preload got cnt %0d amp3 %0d want 2/104", fifo_cnt, amp_all[42 +: 14]); end
      bd();
      checks++; if (active !== 2'd1 || amp_all[0 +: 14] !== 14'd105 || fifo_cnt !== 4'd1) begin errors++; $display("FAIL refill_slot0 got act %0d amp0 %0d cnt %0d want 1/105/1", active, amp_all[0 +: 14], fifo_cnt); end
      bd();
      checks++; if (active !== 2'd2 || start_all[30 +: 30] !== 30'd6000 || fifo_cnt !== 4'd0) begin errors++; $display("FAIL refill_slot1 got act %0d start1 %0d cnt %0d want 2/6000/0", active, start_all[30 +: 30], fifo_cnt); end
      bd(); bd(); bd();
      checks++; if (active !== 2'd1 || busy !== 1'b1 || seq_done !== 1'b0) begin errors++; $display("FAIL refill_bd5 got act %0d busy %0b done %0b want 1/1/0", active, busy, seq_done); end
      bd();
      checks++; if ({seq_done, underrun, set_rst, busy} !== 4'b1010) begin errors++; $display("FAIL refill_done got done/urun/rst/busy %04b want 1010", {seq_done, underrun, set_rst, busy}); end
   endtask

   task automatic test_underrun();
      int n;
      push(1, 1'b0); push(2, 1'b0);
      arm_pulse();
      wait_trig(n);
      checks++; if (n !== 3) begin errors++; $display("FAIL urun_trig_latency got %0d want 3", n); end
      bd();
      checks++; if (active !== 2'd1 || underrun !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL urun_bd1 got act %0d urun %0b busy %0b want 1/0/1", active, underrun, busy); end
      bd();
      checks++; if ({underrun, seq_done, set_rst, busy} !== 4'b1010) begin errors++; $display("FAIL urun_stop got urun/done/rst/busy %04b want 1010", {underrun, seq_done, set_rst, busy}); end
   endtask

   task automatic test_full();
      int n;
      for (int i = 1; i <= 8; i++) push(i, 1'b0);
      checks++; if (fifo_cnt !== 4'd8 || desc_ready !== 1'b0) begin errors++; $display("FAIL full_cnt got cnt %0d ready %0b want 8/0", fifo_cnt, desc_ready); end
      push(9, 1'b0);
      checks++; if (fifo_cnt !== 4'd8) begin errors++; $display("FAIL full_reject got %0d want 8", fifo_cnt); end
      arm_pulse();
      @(negedge clk);
      checks++; if (fifo_cnt !== 4'd7 || desc_ready !== 1'b1) begin errors++; $display("FAIL full_pop got cnt %0d ready %0b want 7/1", fifo_cnt, desc_ready); end
      push(10, 1'b0);
      checks++; if (fifo_cnt !== 4'd7) begin errors++; $display("FAIL full_push_pop got %0d want 7", fifo_cnt); end
      wait_trig(n);
      checks++; if (trig !== 1'b1 || fifo_cnt !== 4'd5) begin errors++; $display("FAIL full_run got trig %0b cnt %0d want 1/5", trig, fifo_cnt); end
   endtask

   task automatic test_abort();
      buf_done = 1'b1;
      abort    = 1'b1;
      @(negedge clk);
      buf_done = 1'b0;
      abort    = 1'b0;
      checks++; if (busy !== 1'b0 || fifo_cnt !== 4'd0 || desc_ready !== 1'b1) begin errors++; $display("FAIL abort_flush got busy %0b cnt %0d ready %0b want 0/0/1", busy, fifo_cnt, desc_ready); end
      checks++; if ({seq_done, underrun, set_rst} !== 3'b001 || active !== 2'd0) begin errors++; $display("FAIL abort_status got done/urun/rst %03b act %0d want 001/0", {seq_done, underrun, set_rst}, active); end
   endtask

   task automatic test_async_reset();
      int n;
      push(1, 1'b0); push(2, 1'b1);
      arm_pulse();
      wait_trig(n);
      bd();
      checks++; if (active !== 2'd1 || set_rst !== 1'b0) begin errors++; $display("FAIL areset_pre got act %0d rst %0b want 1/0", active, set_rst); end
      #2 rstn = 1'b0;
      #1;
      checks++; if ({set_rst, trig, busy, seq_done, underrun, desc_ready} !== 6'b100001) begin errors++; $display("FAIL areset_ctrl got %06b want 100001", {set_rst, trig, busy, seq_done, underrun, desc_ready}); end
      checks++; if (active !== 2'd0 || fifo_cnt !== 4'd0) begin errors++; $display("FAIL areset_ptr got act %0d cnt %0d want 0/0", active, fifo_cnt); end
      checks++; if (amp_all !== 56'd0 || dc_all !== 56'd0 || end_all !== 120'd0 || ncyc_all !== 64'd0) begin errors++; $display("FAIL areset_buses got %h %h want 0", amp_all, end_all); end
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_refill();
      test_underrun();
      test_full();
      test_abort();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
